// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller bundle: the pipeline (master) reports hazard sources and
// consumes stage-register load/zero controls; the controller is the slave.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CNT_BITS = 16
);
  logic [4:0]          id_rs;
  logic [4:0]          id_rt;
  logic                id_uses_rs;
  logic                id_uses_rt;
  logic                ex_mem_read;
  logic [4:0]          ex_rd;
  logic                branch_taken;
  logic                md_start;
  logic                md_is_div;
  logic                halt;
  logic                pc_load;
  logic                ifid_load;
  logic                idex_load;
  logic                ifid_zero;
  logic                idex_zero;
  logic                exmem_zero;
  logic                md_busy;
  logic                md_done;
  logic                halted;
  logic [CNT_BITS-1:0] stall_cnt;
  logic [CNT_BITS-1:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rd,
           branch_taken, md_start, md_is_div, halt,
    input  pc_load, ifid_load, idex_load, ifid_zero, idex_zero, exmem_zero,
           md_busy, md_done, halted, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rd,
           branch_taken, md_start, md_is_div, halt,
    output pc_load, ifid_load, idex_load, ifid_zero, idex_zero, exmem_zero,
           md_busy, md_done, halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/stall/flush controller with multi-cycle mul/div hold and halt.
// Define HAZARD_PERF_CNT_EN to build the saturating stall/flush perf counters.
module pipe_hazard_ctrl #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned CNT_BITS   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int unsigned MaxCycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = ($clog2(MaxCycles) < 1) ? 1 : $clog2(MaxCycles);
  localparam logic [CntW-1:0] MulLoad = CntW'(MUL_CYCLES - 1);
  localparam logic [CntW-1:0] DivLoad = CntW'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {StInit, StRun, StMdBusy, StHalt} state_e;

  state_e          state_q;
  logic [CntW-1:0] md_cnt_q;
  logic            halt_q;
  logic            load_use;
  logic            pc_load, ifid_load, idex_load;
  logic            ifid_zero, idex_zero, exmem_zero;
  logic            md_busy, md_done, halted;

  assign load_use = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                    ((bus.id_uses_rs && (bus.id_rs == bus.ex_rd)) ||
                     (bus.id_uses_rt && (bus.id_rt == bus.ex_rd)));

  always_comb begin
    pc_load    = 1'b0;
    ifid_load  = 1'b0;
    idex_load  = 1'b0;
    ifid_zero  = 1'b0;
    idex_zero  = 1'b0;
    exmem_zero = 1'b0;
    md_busy    = 1'b0;
    md_done    = 1'b0;
    halted     = 1'b0;
    unique case (state_q)
      StRun: begin
        pc_load   = 1'b1;
        ifid_load = 1'b1;
        idex_load = 1'b1;
        // A taken branch squashes the dependent instruction, so no stall is needed.
        if (bus.branch_taken) begin
          ifid_zero = 1'b1;
          idex_zero = 1'b1;
        end else if (load_use) begin
          pc_load   = 1'b0;
          ifid_load = 1'b0;
          idex_zero = 1'b1;
        end
        if (bus.halt) idex_zero = 1'b1;
      end
      StMdBusy: begin
        exmem_zero = 1'b1;
        md_busy    = 1'b1;
        md_done    = (md_cnt_q == '0);
      end
      StHalt: halted = 1'b1;
      default: begin
        ifid_zero  = 1'b1;
        idex_zero  = 1'b1;
        exmem_zero = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StInit;
      md_cnt_q <= '0;
      halt_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StInit: state_q <= StRun;
        StRun: begin
          if (bus.halt) begin
            state_q <= StHalt;
          end else if (bus.md_start) begin
            md_cnt_q <= bus.md_is_div ? DivLoad : MulLoad;
            state_q  <= StMdBusy;
          end
        end
        StMdBusy: begin
          if (md_cnt_q == '0) begin
            state_q <= (halt_q || bus.halt) ? StHalt : StRun;
            halt_q  <= 1'b0;
          end else begin
            md_cnt_q <= md_cnt_q - CntW'(1);
            if (bus.halt) halt_q <= 1'b1;
          end
        end
        StHalt: state_q <= StHalt;
        default: state_q <= StInit;
      endcase
    end
  end

  assign bus.pc_load    = pc_load;
  assign bus.ifid_load  = ifid_load;
  assign bus.idex_load  = idex_load;
  assign bus.ifid_zero  = ifid_zero;
  assign bus.idex_zero  = idex_zero;
  assign bus.exmem_zero = exmem_zero;
  assign bus.md_busy    = md_busy;
  assign bus.md_done    = md_done;
  assign bus.halted     = halted;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_BITS-1:0] stall_cnt_q, flush_cnt_q;
  logic                stall_inc, flush_inc;

  assign stall_inc = !pc_load && ((state_q == StRun) || (state_q == StMdBusy));
  assign flush_inc = (state_q == StRun) && bus.branch_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_inc && (stall_cnt_q != {CNT_BITS{1'b1}})) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_inc && (flush_cnt_q != {CNT_BITS{1'b1}})) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`else
  assign bus.stall_cnt = {CNT_BITS{1'b0}};
  assign bus.flush_cnt = {CNT_BITS{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: inputs change on negedge, outputs checked 1ns later.
// Perf-counter expectations follow HAZARD_PERF_CNT_EN.
module tb_pipe_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
  localparam int unsigned PerfEn = 1;
`else
  localparam int unsigned PerfEn = 0;
`endif

  // {pc_load, ifid_load, idex_load, ifid_zero, idex_zero, exmem_zero, md_busy, md_done, halted}
  localparam logic [8:0] CInit    = 9'b000_111_000;
  localparam logic [8:0] CRun     = 9'b111_000_000;
  localparam logic [8:0] CLoadUse = 9'b001_010_000;
  localparam logic [8:0] CBranch  = 9'b111_110_000;
  localparam logic [8:0] CMdBusy  = 9'b000_001_100;
  localparam logic [8:0] CMdDone  = 9'b000_001_110;
  localparam logic [8:0] CHalt    = 9'b000_000_001;
  localparam logic [8:0] CHaltReq = 9'b111_010_000;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_stall = 0;
  int   exp_flush = 0;
  logic [8:0] ctrl;

  pipe_hazard_ctrl_if #(.CNT_BITS(16)) bus ();

  pipe_hazard_ctrl #(
    .MUL_CYCLES(4),
    .DIV_CYCLES(32),
    .CNT_BITS  (16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  assign ctrl = {bus.pc_load, bus.ifid_load, bus.idex_load, bus.ifid_zero, bus.idex_zero,
                 bus.exmem_zero, bus.md_busy, bus.md_done, bus.halted};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_cnts(input string tag);
    check_eq({tag, " stall_cnt"}, 32'(bus.stall_cnt), 32'(exp_stall));
    check_eq({tag, " flush_cnt"}, 32'(bus.flush_cnt), 32'(exp_flush));
  endtask

  task automatic idle_inputs();
    bus.id_rs        = 5'd0;
    bus.id_rt        = 5'd0;
    bus.id_uses_rs   = 1'b0;
    bus.id_uses_rt   = 1'b0;
    bus.ex_mem_read  = 1'b0;
    bus.ex_rd        = 5'd0;
    bus.branch_taken = 1'b0;
    bus.md_start     = 1'b0;
    bus.md_is_div    = 1'b0;
    bus.halt         = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                              input logic urs, input logic urt);
    bus.ex_mem_read = 1'b1;
    bus.ex_rd       = rd;
    bus.id_rs       = rs;
    bus.id_rt       = rt;
    bus.id_uses_rs  = urs;
    bus.id_uses_rt  = urt;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk); #1;
    check_eq("reset ctrl", 32'(ctrl), 32'(CInit));
    check_cnts("reset");

    @(negedge clk); rst_n = 1'b1; #1;
    check_eq("init cycle", 32'(ctrl), 32'(CInit));
    @(negedge clk); #1;
    check_eq("run default", 32'(ctrl), 32'(CRun));

    // Load-use via rs, then release.
    @(negedge clk); set_load_use(5'd5, 5'd5, 5'd0, 1'b1, 1'b0); #1;
    check_eq("load-use rs", 32'(ctrl), 32'(CLoadUse));
    exp_stall += PerfEn;
    @(negedge clk); idle_inputs(); #1;
    check_eq("after load-use", 32'(ctrl), 32'(CRun));
    check_cnts("after load-use");

    @(negedge clk); set_load_use(5'd7, 5'd1, 5'd7, 1'b0, 1'b1); #1;
    check_eq("load-use rt", 32'(ctrl), 32'(CLoadUse));
    exp_stall += PerfEn;
    @(negedge clk); set_load_use(5'd9, 5'd9, 5'd9, 1'b0, 1'b0); #1;
    check_eq("match without use", 32'(ctrl), 32'(CRun));
    @(negedge clk); set_load_use(5'd0, 5'd0, 5'd0, 1'b1, 1'b1); #1;
    check_eq("rd zero no stall", 32'(ctrl), 32'(CRun));

    // Branch wins over coincident load-use.
    @(negedge clk); set_load_use(5'd3, 5'd3, 5'd0, 1'b1, 1'b0); bus.branch_taken = 1'b1; #1;
    check_eq("branch+load-use", 32'(ctrl), 32'(CBranch));
    exp_flush += PerfEn;
    @(negedge clk); idle_inputs(); bus.branch_taken = 1'b1; #1;
    check_cnts("after branch+load-use");
    check_eq("branch only", 32'(ctrl), 32'(CBranch));
    exp_flush += PerfEn;

    // Divide: 32 busy cycles, hazards ignored mid-way.
    @(negedge clk); idle_inputs(); bus.md_start = 1'b1; bus.md_is_div = 1'b1; #1;
    check_eq("md_start div", 32'(ctrl), 32'(CRun));
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk); idle_inputs();
      if (i == 5) begin
        set_load_use(5'd4, 5'd4, 5'd0, 1'b1, 1'b0);
        bus.branch_taken = 1'b1;
        bus.md_start     = 1'b1;
      end
      #1;
      check_eq($sformatf("div busy %0d", i), 32'(ctrl), 32'((i == 32) ? CMdDone : CMdBusy));
    end
    exp_stall += 32 * PerfEn;
    @(negedge clk); idle_inputs(); #1;
    check_eq("div exit run", 32'(ctrl), 32'(CRun));
    check_cnts("after div");

    // Multiply with halt in busy cycle 3.
    @(negedge clk); bus.md_start = 1'b1; bus.md_is_div = 1'b0; #1;
    check_eq("md_start mul", 32'(ctrl), 32'(CRun));
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); idle_inputs();
      if (i == 3) bus.halt = 1'b1;
      #1;
      check_eq($sformatf("mul busy %0d", i), 32'(ctrl), 32'((i == 4) ? CMdDone : CMdBusy));
    end
    exp_stall += 4 * PerfEn;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle_inputs(); bus.branch_taken = 1'b1; #1;
      check_eq($sformatf("halt sticky %0d", i), 32'(ctrl), 32'(CHalt));
    end
    check_cnts("halted");

    @(negedge clk); idle_inputs(); rst_n = 1'b0; #1;
    exp_stall = 0;
    exp_flush = 0;
    check_eq("reset from halt", 32'(ctrl), 32'(CInit));
    check_cnts("reset from halt");
    @(negedge clk); rst_n = 1'b1; #1;
    check_eq("init after halt", 32'(ctrl), 32'(CInit));
    @(negedge clk); #1;
    check_eq("run after halt", 32'(ctrl), 32'(CRun));

    // Asynchronous reset mid-divide.
    @(negedge clk); bus.md_start = 1'b1; bus.md_is_div = 1'b1; #1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); idle_inputs();
    end
    #1;
    check_eq("mid div busy", 32'(ctrl), 32'(CMdBusy));
    #1; rst_n = 1'b0; #1;
    check_eq("async reset mid div", 32'(ctrl), 32'(CInit));
    check_eq("async reset stall_cnt", 32'(bus.stall_cnt), 32'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    check_eq("init after async", 32'(ctrl), 32'(CInit));
    @(negedge clk); #1;
    check_eq("run after async", 32'(ctrl), 32'(CRun));

    // Halt from RUN.
    @(negedge clk); bus.halt = 1'b1; #1;
    check_eq("halt request", 32'(ctrl), 32'(CHaltReq));
    @(negedge clk); idle_inputs(); set_load_use(5'd6, 5'd6, 5'd0, 1'b1, 1'b0); #1;
    check_eq("halted", 32'(ctrl), 32'(CHalt));
    @(negedge clk); idle_inputs(); #1;
    check_eq("halted hold", 32'(ctrl), 32'(CHalt));
    check_cnts("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
